// File: rtl/keypad_matrix_scanner.sv
// Row/column keypad scanner: a one-hot column strobe advances on a divided scan tick;
// one key at a time is locked on, debounced over DEBOUNCE ticks, and reported with press/release pulses.
module keypad_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 12500,
    parameter int DEBOUNCE = 4,
    localparam int CW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] key_row,
    output logic [COLS-1:0] key_col,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            key_release
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COLW = $clog2(COLS);

    localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0]  DEB_DONE    = DBW'(DEBOUNCE);
    localparam logic [COLW-1:0] COL_LAST    = COLW'(COLS - 1);
    localparam logic [COLS-1:0] COL0_ONEHOT = {{(COLS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2
    } state_t;

    state_t          state_q,       state_d;
    logic [DIVW-1:0] div_cnt_q,     div_cnt_d;
    logic [COLW-1:0] col_idx_q,     col_idx_d;
    logic [RW-1:0]   row_idx_q,     row_idx_d;
    logic [DBW-1:0]  deb_cnt_q,     deb_cnt_d;
    logic [COLS-1:0] key_col_q,     key_col_d;
    logic [CW-1:0]   key_code_q,    key_code_d;
    logic            key_valid_q,   key_valid_d;
    logic            key_held_q,    key_held_d;
    logic            key_release_q, key_release_d;

    logic            tick;
    logic            row_hit;
    logic [COLW-1:0] col_next;
    logic [DBW-1:0]  deb_inc;
    logic [RW-1:0]   row_first;

    // Lowest-index asserted row wins when several keys in one column are closed.
    function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] rows);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = RW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] code_of(input logic [RW-1:0] row, input logic [COLW-1:0] col);
        return CW'(int'(row) * COLS + int'(col));
    endfunction

    assign tick      = (div_cnt_q == DIV_LAST);
    assign row_hit   = key_row[row_idx_q];
    assign col_next  = (col_idx_q == COL_LAST) ? '0 : col_idx_q + COLW'(1);
    assign deb_inc   = deb_cnt_q + DBW'(1);
    assign row_first = lowest_row(key_row);

    // Next-state and output computation; every FSM action is gated by the scan tick.
    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        deb_cnt_d     = deb_cnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_held_d    = key_held_q;
        key_release_d = 1'b0;
        div_cnt_d     = tick ? '0 : div_cnt_q + DIVW'(1);

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (key_row == '0) begin
                        col_idx_d = col_next;
                    end else begin
                        row_idx_d = row_first;
                        if (DEBOUNCE == 1) begin
                            key_code_d  = code_of(row_first, col_idx_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_cnt_d   = '0;
                            state_d     = ST_HELD;
                        end else begin
                            deb_cnt_d = DBW'(1);
                            state_d   = ST_PRESS_DEB;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (row_hit) begin
                        if (deb_inc == DEB_DONE) begin
                            key_code_d  = code_of(row_idx_q, col_idx_q);
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            deb_cnt_d   = '0;
                            state_d     = ST_HELD;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        col_idx_d = col_next;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // Any high sample restarts the release count, so release bounce is absorbed.
                    if (!row_hit) begin
                        if (deb_inc == DEB_DONE) begin
                            key_release_d = 1'b1;
                            key_held_d    = 1'b0;
                            deb_cnt_d     = '0;
                            col_idx_d     = col_next;
                            state_d       = ST_SCAN;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: begin
                    deb_cnt_d  = '0;
                    key_held_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        key_col_d = COL0_ONEHOT << col_idx_d;
    end

    // State and output registers with synchronous reset taking priority over the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SCAN;
            div_cnt_q     <= '0;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            deb_cnt_q     <= '0;
            key_col_q     <= COL0_ONEHOT;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_held_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            deb_cnt_q     <= deb_cnt_d;
            key_col_q     <= key_col_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_held_q    <= key_held_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_col     = key_col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign key_release = key_release_q;

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised row/column keypad scanner with debounced press and release events, for generic ROWS×COLS matrices. It drives a one-hot column strobe from a divided scan tick and samples the active-high row inputs. A single key is locked on, debounced over a programmable number of scan ticks, and reported as a linear key code with one-cycle press and release pulses. It sits between the keypad pins and the control FSM that consumes digits and command keys.

## Interface
- `ROWS`, default 4: number of row inputs, ≥1.
- `COLS`, default 3: number of column outputs, ≥2.
- `SCAN_DIV`, default 12500: `clk` cycles per scan tick, ≥2.
- `DEBOUNCE`, default 4: consecutive ticks needed to confirm a press or a release, ≥1.
- `CW`, derived: `max(1, $clog2(ROWS*COLS))`.

- `clk`, in, 1: single system clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `key_row`, in, ROWS: row sense; 1 means a key in the driven column is closed.
- `key_col`, out, COLS: one-hot column drive.
- `key_code`, out, CW: `row*COLS + col` of the last confirmed key.
- `key_valid`, out, 1: one-cycle pulse when a press is confirmed.
- `key_held`, out, 1: level; high from confirmed press until confirmed release.
- `key_release`, out, 1: one-cycle pulse when a release is confirmed.

## Operation
- **Prescaler.** `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (`div_cnt == SCAN_DIV-1`). All FSM actions below happen only on `tick` cycles.
- **Column index.** `col_idx` runs 0..COLS-1 and wraps to 0. `key_col` = `1 << col_idx`.
- **States:**
  - SCAN:
    - `key_row == 0` → increment `col_idx`.
    - Any row high → latch `row_idx` as the lowest-index high row, set `deb_cnt` = 1, hold `col_idx`.
    - If DEBOUNCE == 1, go straight to the press-confirm action; otherwise go to PRESS_DEB.
  - PRESS_DEB:
    - `key_row[row_idx]` = 1 → increment `deb_cnt`.
    - When `deb_cnt` reaches DEBOUNCE (press-confirm action): `key_code` ← `row_idx*COLS + col_idx`, pulse `key_valid`, set `key_held`, clear `deb_cnt`, go to HELD.
    - `key_row[row_idx]` = 0 → go to SCAN and increment `col_idx`.
  - HELD:
    - `key_row[row_idx]` = 0 → increment `deb_cnt`.
    - `key_row[row_idx]` = 1 → clear `deb_cnt`.
    - When `deb_cnt` reaches DEBOUNCE: pulse `key_release`, clear `key_held`, go to SCAN and increment `col_idx`.
- **One key at a time.** The column stays frozen outside SCAN. Other rows or keys are ignored until release completes. Simultaneous keys in one column resolve to the lowest row.
- **Key code hold.** `key_code` holds its value after release until the next confirmed press.
- **Arithmetic.** The code computation is unsigned and sized to CW. `deb_cnt` is sized for DEBOUNCE.

## Timing
- **Reset values:**
  - `key_col` = 1 (column 0); `key_code` = 0.
  - `key_valid`, `key_held`, `key_release` = 0.
  - `div_cnt`, `deb_cnt`, `col_idx` = 0; state = SCAN.
- **Registered outputs.** All outputs are registered. Effects of a tick appear on the cycle after the tick edge.
- **Column settle.** `key_col` changes only on the cycle after a tick. `key_row` is sampled SCAN_DIV-1 cycles later, which gives the column time to settle.
- **Press latency.** A row held steady from its first sampled tick gives `key_valid` one cycle after the DEBOUNCE-th consecutive high tick.
- **Pulse width.** `key_valid` and `key_release` are exactly one `clk` cycle wide, never both in the same cycle. Each press yields exactly one `key_valid` and one `key_release`.
- **Reset mid-operation.** `rst` mid-operation aborts any state with no pulse emitted. It has priority over `tick`.
- **Glitch rejection.** A glitch shorter than DEBOUNCE ticks produces no pulse.

## Test plan
- **Reset.** Set SCAN_DIV=4, DEBOUNCE=3, hold `rst` for 3 cycles → `key_col`=3'b001 and all outputs 0. After release, `key_col` steps 001→010→100→001 every 4 cycles.
- **Clean press.** Assert `key_row`=4'b0100 whenever column 1 is driven, for 5 ticks → `key_valid` pulses once with `key_code`=7, `key_held`=1, and `key_col` frozen at 010. Drop the row → `key_release` pulses after 3 low ticks and scanning resumes at column 2.
- **Bounce.** On column 0, row pattern 1,1,0 across successive ticks → no `key_valid`; the FSM returns to SCAN. A later steady press on row 3 col 2 → `key_code`=11.
- **Release bounce.** In HELD, row pattern low,low,high,low,low,low → exactly one `key_release`, after the final third low tick.
- **Multi-key.** `key_row`=4'b1010 in column 2 → `key_code`=5 (row 1). Adding row 0 while held → no new `key_valid`.
- **Reset mid-debounce.** Assert `rst` during PRESS_DEB → no pulses; `key_col`=001 next cycle. Also re-run the suite with ROWS=2, COLS=2, DEBOUNCE=1 → codes 0..3 and `key_valid` one cycle after the first sampled tick.
